// File: rtl/seven_seg_decoder_if.sv
// Bus bundle for the seven-segment receive decoder: the scanned display pins
// and clear on one side, and the rebuilt display state and update strobe on the other.
interface seven_seg_decoder_if;
    logic [7:0]  anode;
    logic [6:0]  cathode;
    logic        clear;
    logic [31:0] digits;
    logic [7:0]  digit_valid;
    logic        update;
    logic [2:0]  update_sel;
    logic [3:0]  update_num;
    logic        frame_done;
    logic        bad_pattern;
    logic        bad_anode;

    // Stimulus / scanner side: drives the pins, observes the decoded result.
    modport master (
        output anode, cathode, clear,
        input  digits, digit_valid, update, update_sel, update_num,
               frame_done, bad_pattern, bad_anode
    );

    // Decoder side.
    modport slave (
        input  anode, cathode, clear,
        output digits, digit_valid, update, update_sel, update_num,
               frame_done, bad_pattern, bad_anode
    );
endinterface

// File: rtl/seven_seg_decoder.sv
// Receive-side decoder for an 8-digit multiplexed seven-segment bus.
// Registers the anode/cathode pins, waits for the pair to settle for
// STABLE_CYCLES, then decodes the segment pattern back to a hex nibble and
// rebuilds the display contents, emitting one update strobe per capture.
// Optional build macro SEVSEG_DEC_CHANGE_ONLY_EN: update fires only when the
// captured nibble is new for that digit.
module seven_seg_decoder #(
    parameter int unsigned STABLE_CYCLES = 16
) (
    input logic                clock,
    input logic                reset_n,
    seven_seg_decoder_if.slave bus
);

    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_FIRE = CW'(STABLE_CYCLES - 1);

    // Input stage and the copy used to detect a change from one cycle to the next.
    logic [7:0]    anode_q, anode_qq;
    logic [6:0]    cathode_q, cathode_qq;
    logic [CW-1:0] stab_cnt;

    // Captured display state.
    logic [31:0] digits_q;
    logic [7:0]  valid_q;
    logic [7:0]  seen_q;
    logic        update_q;
    logic [2:0]  sel_q;
    logic [3:0]  num_q;
    logic        frame_q;
    logic        bad_pat_q;
    logic        bad_an_q;

    // Combinational decode of the settled pair.
    logic       changed;
    logic       accept;
    logic       is_blank;
    logic       is_onehot;
    logic [2:0] sel;
    logic       dec_ok;
    logic [3:0] nib;
    logic       do_capture;
    logic       emit;
    logic       set_bad_pat;
    logic       set_bad_an;
    logic [7:0] seen_next;
    logic       frame_complete;

    // Segment pattern to hex nibble; returns {ok, nibble}.
    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        case (seg)
            7'h3F:   return {1'b1, 4'h0};
            7'h06:   return {1'b1, 4'h1};
            7'h5B:   return {1'b1, 4'h2};
            7'h4F:   return {1'b1, 4'h3};
            7'h66:   return {1'b1, 4'h4};
            7'h6D:   return {1'b1, 4'h5};
            7'h7D:   return {1'b1, 4'h6};
            7'h07:   return {1'b1, 4'h7};
            7'h7F:   return {1'b1, 4'h8};
            7'h6F:   return {1'b1, 4'h9};
            7'h77:   return {1'b1, 4'hA};
            7'h7C:   return {1'b1, 4'hB};
            7'h39:   return {1'b1, 4'hC};
            7'h5E:   return {1'b1, 4'hD};
            7'h79:   return {1'b1, 4'hE};
            7'h71:   return {1'b1, 4'hF};
            default: return {1'b0, 4'h0};
        endcase
    endfunction

    // Classify the settled pair and decide what the accept event does.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        sel            = 3'd0;
        dec_ok         = 1'b0;
        nib            = 4'h0;
        emit           = 1'b0;

        changed   = (anode_q != anode_qq) || (cathode_q != cathode_qq);
        accept    = (stab_cnt == CNT_FIRE);
        is_blank  = (anode_qq == 8'hFF);
        is_onehot = $onehot(~anode_qq);

        for (int i = 0; i < 8; i++) begin
            if (!anode_qq[i]) sel = i[2:0];
        end

        {dec_ok, nib} = decode_seg(cathode_qq);

        do_capture  = accept && is_onehot && dec_ok;
        set_bad_pat = accept && is_onehot && !dec_ok;
        set_bad_an  = accept && !is_blank && !is_onehot;

`ifdef SEVSEG_DEC_CHANGE_ONLY_EN
        emit = do_capture && (!valid_q[sel] || (digits_q[4*sel +: 4] != nib));
`else
        emit = do_capture;
`endif

        seen_next      = seen_q | (8'b1 << sel);
        frame_complete = do_capture && (seen_next == 8'hFF);
    end

    // Register the pins and count how long the registered pair has held still.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (!reset_n) begin
            anode_q    <= '0;
            anode_qq   <= '0;
            cathode_q  <= '0;
            cathode_qq <= '0;
            stab_cnt   <= '0;
        end else begin
            anode_q    <= bus.anode;
            cathode_q  <= bus.cathode;
            anode_qq   <= anode_q;
            cathode_qq <= cathode_q;
            if (changed)
                stab_cnt <= '0;
            else if (stab_cnt != CNT_MAX)
                stab_cnt <= stab_cnt + 1'b1;
        end
    end

    // Apply an accept event to the display image, strobes and sticky flags.
    always_ff @(posedge clock) begin
        // NOTE: the digit store is only 32 flops, so it is reset with everything
        // else; readers can rely on zeros after reset without checking digit_valid.
        if (!reset_n) begin
            digits_q  <= '0;
            valid_q   <= '0;
            seen_q    <= '0;
            update_q  <= 1'b0;
            sel_q     <= '0;
            num_q     <= '0;
            frame_q   <= 1'b0;
            bad_pat_q <= 1'b0;
            bad_an_q  <= 1'b0;
        end else if (bus.clear) begin
            // Clear wins over a coincident accept; the strobe fields keep their last values.
            digits_q  <= '0;
            valid_q   <= '0;
            seen_q    <= '0;
            update_q  <= 1'b0;
            frame_q   <= 1'b0;
            bad_pat_q <= 1'b0;
            bad_an_q  <= 1'b0;
        end else begin
            update_q <= emit;
            frame_q  <= frame_complete;
            if (emit) begin
                sel_q <= sel;
                num_q <= nib;
            end
            if (do_capture) begin
                digits_q[4*sel +: 4] <= nib;
                valid_q[sel]         <= 1'b1;
                seen_q               <= frame_complete ? 8'h00 : seen_next;
            end
            if (set_bad_pat) bad_pat_q <= 1'b1;
            if (set_bad_an)  bad_an_q  <= 1'b1;
        end
    end

    assign bus.digits      = digits_q;
    assign bus.digit_valid = valid_q;
    assign bus.update      = update_q;
    assign bus.update_sel  = sel_q;
    assign bus.update_num  = num_q;
    assign bus.frame_done  = frame_q;
    assign bus.bad_pattern = bad_pat_q;
    assign bus.bad_anode   = bad_an_q;

endmodule

// File: tb/tb_seven_seg_decoder.sv
// Directed bench for seven_seg_decoder with STABLE_CYCLES=16: settle latency,
// glitch rejection, full-frame scans, error flags, clear and reset priority.
module tb_seven_seg_decoder;

    logic clock = 1'b0;
    logic reset_n;

    seven_seg_decoder_if bus ();

    seven_seg_decoder #(.STABLE_CYCLES(16)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Pulse monitor, sampled on the falling edge.
    int         upd_count   = 0;
    int         fd_count    = 0;
    int         last_upd_cyc = -1;
    int         last_fd_cyc  = -1;
    logic [2:0] last_sel = '0;
    logic [3:0] last_num = '0;
    always @(negedge clock) begin
        if (bus.update) begin
            upd_count    = upd_count + 1;
            last_upd_cyc = cyc;
            last_sel     = bus.update_sel;
            last_num     = bus.update_num;
        end
        if (bus.frame_done) begin
            fd_count    = fd_count + 1;
            last_fd_cyc = cyc;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a pin pair and let it run for n clock edges; returns 1 time unit after the last edge.
    task automatic hold(input logic [7:0] an, input logic [6:0] ca, input int n);
        bus.anode   = an;
        bus.cathode = ca;
        repeat (n) @(posedge clock);
        #1;
    endtask

    function automatic logic [6:0] seg_of(input int v);
        case (v)
            0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F;
            4: return 7'h66; 5: return 7'h6D; 6: return 7'h7D; default: return 7'h07;
        endcase
    endfunction

    int n0, u0, f0, r0;

    initial begin
        reset_n     = 1'b0;
        bus.anode   = 8'hFF;
        bus.cathode = 7'h00;
        bus.clear   = 1'b0;
        repeat (3) @(posedge clock);
        #1;

        // Reset state.
        check("rst_digits", bus.digits, 32'h0);
        check("rst_valid",  {24'h0, bus.digit_valid}, 32'h0);
        check("rst_update", {31'h0, bus.update}, 32'h0);
        check("rst_flags",  {30'h0, bus.bad_pattern, bus.bad_anode}, 32'h0);

        // Single settle on digit 0: one update 17 cycles after the first sampling edge.
        reset_n = 1'b1;
        n0 = cyc; u0 = upd_count;
        hold(8'hFE, 7'h5B, 30);
        check("t1_upd_count", upd_count - u0, 1);
        check("t1_upd_cyc",   last_upd_cyc, n0 + 18);
        check("t1_sel",       {29'h0, last_sel}, 32'd0);
        check("t1_num",       {28'h0, last_num}, 32'd2);
        check("t1_digits",    bus.digits, 32'h00000002);
        check("t1_valid",     {24'h0, bus.digit_valid}, 32'h01);
        check("t1_flags",     {30'h0, bus.bad_pattern, bus.bad_anode}, 32'h0);

        // Cathode toggling every 5 cycles never settles.
        u0 = upd_count;
        for (int k = 0; k < 20; k++) hold(8'hFD, (k % 2 == 0) ? 7'h06 : 7'h4F, 5);
        check("t2_upd_count", upd_count - u0, 0);
        check("t2_digits",    bus.digits, 32'h00000002);
        check("t2_valid",     {24'h0, bus.digit_valid}, 32'h01);

        // Two full scans, each completing exactly one frame on the digit-7 update.
        u0 = upd_count; f0 = fd_count;
        for (int d = 0; d < 8; d++) hold(~(8'h01 << d), seg_of(d), 20);
        check("t3_digits",    bus.digits, 32'h76543210);
        check("t3_valid",     {24'h0, bus.digit_valid}, 32'hFF);
        check("t3_upd_count", upd_count - u0, 8);
        check("t3_fd_count",  fd_count - f0, 1);
        check("t3_fd_cyc",    last_fd_cyc, last_upd_cyc);
        check("t3_last_sel",  {29'h0, last_sel}, 32'd7);
        for (int d = 0; d < 8; d++) hold(~(8'h01 << d), seg_of(d), 20);
        check("t3_fd_count2", fd_count - f0, 2);

        // Error flags, blank anode, then clear.
        u0 = upd_count;
        hold(8'hF7, 7'h00, 20);
        check("t4_bad_pat",   {31'h0, bus.bad_pattern}, 32'h1);
        check("t4_digit3",    {28'h0, bus.digits[15:12]}, 32'h3);
        hold(8'hF3, 7'h4F, 20);
        check("t4_bad_an",    {31'h0, bus.bad_anode}, 32'h1);
        hold(8'hFF, 7'h4F, 20);
        check("t4_upd_count", upd_count - u0, 0);
        check("t4_flags_hold", {30'h0, bus.bad_pattern, bus.bad_anode}, 32'h3);
        bus.clear = 1'b1;
        @(posedge clock); #1;
        bus.clear = 1'b0;
        check("t4_flags_clr", {30'h0, bus.bad_pattern, bus.bad_anode}, 32'h0);
        check("t4_digits_clr", bus.digits, 32'h0);

        // Clear on the exact accept cycle discards the capture.
        hold(8'hFD, 7'h06, 20);
        check("t5_pre_valid", {24'h0, bus.digit_valid}, 32'h02);
        u0 = upd_count; f0 = fd_count;
        n0 = cyc;
        hold(8'hFE, 7'h3F, 17);
        bus.clear = 1'b1;
        @(posedge clock); #1;
        bus.clear = 1'b0;
        hold(8'hFE, 7'h3F, 10);
        check("t5_upd_count", upd_count - u0, 0);
        check("t5_fd_count",  fd_count - f0, 0);
        check("t5_valid",     {24'h0, bus.digit_valid}, 32'h00);

        // Reset mid-hold zeroes everything; the hold restarts after release.
        hold(8'hFB, 7'h5B, 20);
        check("t6_pre_digits", bus.digits, 32'h00000200);
        hold(8'hF7, 7'h4F, 10);
        reset_n = 1'b0;
        @(posedge clock); #1;
        check("t6_rst_digits", bus.digits, 32'h0);
        check("t6_rst_valid",  {24'h0, bus.digit_valid}, 32'h0);
        check("t6_rst_strobe", {23'h0, bus.update, bus.update_sel, bus.update_num, bus.frame_done},
              32'h0);
        reset_n = 1'b1;
        r0 = cyc; u0 = upd_count;
        hold(8'hF7, 7'h4F, 30);
        check("t6_upd_count", upd_count - u0, 1);
        check("t6_upd_cyc",   last_upd_cyc, r0 + 18);
        check("t6_num",       {28'h0, last_num}, 32'd3);
        check("t6_digits",    bus.digits, 32'h00003000);

        // Repeated identical capture on digit 5, then a new value.
        u0 = upd_count;
        hold(8'hDF, 7'h66, 20);
        hold(8'hFF, 7'h00, 5);
        hold(8'hDF, 7'h66, 20);
`ifdef SEVSEG_DEC_CHANGE_ONLY_EN
        check("t7_same_upd",  upd_count - u0, 1);
`else
        check("t7_same_upd",  upd_count - u0, 2);
`endif
        u0 = upd_count;
        hold(8'hDF, 7'h6D, 20);
        check("t7_new_upd",   upd_count - u0, 1);
        check("t7_new_num",   {28'h0, last_num}, 32'd5);
        check("t7_digits",    bus.digits, 32'h00503000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
